// File: rtl/stopwatch_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd_if
//  Description : Control-pulse, preset and BCD display bundle between the
//                key/tick logic (master) and the stopwatch core (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_bcd_if;
  // Control side: 100 Hz square wave, one-cycle key pulses, preset load
  logic        tick_100hz;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic        preload;
  logic [23:0] preload_val;  // {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones}

  // Display side: six BCD digits and status flags
  logic [3:0]  cs_ones;
  logic [3:0]  cs_tens;
  logic [3:0]  s_ones;
  logic [3:0]  s_tens;
  logic [3:0]  m_ones;
  logic [3:0]  m_tens;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport master (
    output tick_100hz, start_stop, clear, lap, preload, preload_val,
    input  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
           running, lap_active, overflow
  );

  modport slave (
    input  tick_100hz, start_stop, clear, lap, preload, preload_val,
    output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
           running, lap_active, overflow
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd
//  Description : mm:ss.cc BCD stopwatch paced by a 100 Hz square wave, with
//                run/pause, clear, lap freeze and wrap-or-saturate at
//                59:59.99. Digit and status outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_bcd #(
  parameter bit WRAP = 1'b1   // 1: roll over to 00:00.00, 0: saturate
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  stopwatch_bcd_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  // Per-digit upper limits, same packing as the count: 59:59.99
  localparam logic [23:0] MAX_TIME = 24'h595999;

  state_t      state_q;
  logic        tick_dly_q;   // previous tick sample; resets high to mask a false edge
  logic [23:0] cnt_q;        // live count
  logic [23:0] lap_q;        // frozen lap snapshot
  logic        lap_act_q;
  logic        ovf_q;

  logic [23:0] disp_q;
  logic        running_q;
  logic        lap_out_q;
  logic        ovf_out_q;

  logic [23:0] inc_d;        // count + 1 centisecond
  logic        wrap_d;       // every digit at its limit: this increment rolls over
  logic        tick_ev;
  logic        count_en;
  logic        sat_ev;

  assign tick_ev  = bus.tick_100hz & ~tick_dly_q;
  assign count_en = (state_q == S_RUN) && tick_ev && !bus.preload;
  assign sat_ev   = count_en && wrap_d && !WRAP;

  // BCD ripple increment; a digit at or above its limit returns to 0 and carries
  always_comb begin
    inc_d  = cnt_q;
    wrap_d = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (wrap_d) begin
        if (cnt_q[4*i +: 4] >= MAX_TIME[4*i +: 4]) begin
          inc_d[4*i +: 4] = 4'd0;
        end else begin
          inc_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          wrap_d          = 1'b0;
        end
      end
    end
  end

  // Control FSM, counter, lap register and overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_dly_q <= 1'b1;
      cnt_q      <= 24'd0;
      lap_q      <= 24'd0;
      lap_act_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tick_dly_q <= bus.tick_100hz;
      if (bus.clear) begin
        // Clear discards any coincident tick, key or preset
        state_q   <= S_IDLE;
        cnt_q     <= 24'd0;
        lap_q     <= 24'd0;
        lap_act_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        // Wrap mode: overflow is a single-cycle pulse
        if (WRAP) begin
          ovf_q <= 1'b0;
        end

        if (bus.preload) begin
          cnt_q <= bus.preload_val;
        end else if (count_en) begin
          if (wrap_d) begin
            ovf_q <= 1'b1;
          end
          // Saturation holds 59:59.99; otherwise inc_d already holds all zeros
          if (!wrap_d || WRAP) begin
            cnt_q <= inc_d;
          end
        end

        // start_stop outranks lap; a discarded lap is not remembered
        if (bus.start_stop) begin
          case (state_q)
            S_IDLE:  state_q <= S_RUN;
            S_RUN:   state_q <= S_PAUSE;
            S_PAUSE: state_q <= S_RUN;
            default: state_q <= state_q;
          endcase
        end else if (bus.lap) begin
          if (lap_act_q) begin
            lap_act_q <= 1'b0;
          end else if (state_q == S_RUN) begin
            lap_q     <= cnt_q;
            lap_act_q <= 1'b1;
          end
        end

        // Reaching full scale without wrap overrides any same-cycle pause
        if (sat_ev) begin
          state_q <= S_FULL;
        end
      end
    end
  end

  // Output register stage: display mux and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q    <= 24'd0;
      running_q <= 1'b0;
      lap_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      disp_q    <= lap_act_q ? lap_q : cnt_q;
      running_q <= (state_q == S_RUN);
      lap_out_q <= lap_act_q;
      ovf_out_q <= ovf_q;
    end
  end

  assign bus.cs_ones    = disp_q[3:0];
  assign bus.cs_tens    = disp_q[7:4];
  assign bus.s_ones     = disp_q[11:8];
  assign bus.s_tens     = disp_q[15:12];
  assign bus.m_ones     = disp_q[19:16];
  assign bus.m_tens     = disp_q[23:20];
  assign bus.running    = running_q;
  assign bus.lap_active = lap_out_q;
  assign bus.overflow   = ovf_out_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_bcd
//  Description : Bench for stopwatch_bcd. Drives a wrapping and a saturating
//                instance with identical stimulus; table vectors, corner
//                sequences and random traffic against a time-in-centiseconds
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_bcd;

  localparam int H       = 2;        // tick half period in clk cycles
  localparam int FULL_CS = 360000;   // centiseconds in one hour
  localparam int OP_RST = 0, OP_SS = 1, OP_CLR = 2, OP_LAP = 3, OP_TICKS = 4, OP_LOAD = 5;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_FULL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic tick = 1'b0, ss = 1'b0, clr = 1'b0, lapp = 1'b0, pl = 1'b0;
  int   pl_cs = 0;
  bit   tick_on = 1'b0;
  int   ph = 0;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model, index 0 = WRAP=1 instance, 1 = WRAP=0 instance
  int m_state [2];
  int m_cnt   [2];
  int m_lap   [2];
  bit m_lapact[2];
  bit m_ovf   [2];
  bit m_tickd = 1'b1;
  bit last_ev = 1'b0;
  int e_disp  [2];
  bit e_run   [2];
  bit e_lap   [2];
  bit e_ovf   [2];

  function automatic logic [23:0] to_bcd(int t);
    int cs, s, m;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = t / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic int to_cs(int m, int s, int c);
    return m * 6000 + s * 100 + c;
  endfunction

  stopwatch_bcd_if bus_w ();
  stopwatch_bcd_if bus_s ();

  assign bus_w.tick_100hz = tick;
  assign bus_w.start_stop = ss;
  assign bus_w.clear = clr;
  assign bus_w.lap = lapp;
  assign bus_w.preload = pl;
  assign bus_w.preload_val = to_bcd(pl_cs);
  assign bus_s.tick_100hz = tick;
  assign bus_s.start_stop = ss;
  assign bus_s.clear = clr;
  assign bus_s.lap = lapp;
  assign bus_s.preload = pl;
  assign bus_s.preload_val = to_bcd(pl_cs);

  stopwatch_bcd #(.WRAP(1'b1)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w.slave));
  stopwatch_bcd #(.WRAP(1'b0)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

  logic [26:0] dv [2];
  assign dv[0] = {bus_w.m_tens, bus_w.m_ones, bus_w.s_tens, bus_w.s_ones, bus_w.cs_tens,
                  bus_w.cs_ones, bus_w.running, bus_w.lap_active, bus_w.overflow};
  assign dv[1] = {bus_s.m_tens, bus_s.m_ones, bus_s.s_tens, bus_s.s_ones, bus_s.cs_tens,
                  bus_s.cs_ones, bus_s.running, bus_s.lap_active, bus_s.overflow};

  // One clock edge of the behavioural model, using the inputs about to be sampled
  task automatic model_step();
    bit ev;
    ev = tick && !m_tickd;
    last_ev = ev && rst_n;
    for (int k = 0; k < 2; k++) begin
      int os, oc;
      bit sat;
      e_disp[k] = m_lapact[k] ? m_lap[k] : m_cnt[k];
      e_run[k]  = (m_state[k] == ST_RUN);
      e_lap[k]  = m_lapact[k];
      e_ovf[k]  = m_ovf[k];
      sat = 1'b0;
      if (!rst_n) begin
        m_state[k] = ST_IDLE; m_cnt[k] = 0; m_lap[k] = 0; m_lapact[k] = 0; m_ovf[k] = 0;
        e_disp[k] = 0; e_run[k] = 0; e_lap[k] = 0; e_ovf[k] = 0;
      end else if (clr) begin
        m_state[k] = ST_IDLE; m_cnt[k] = 0; m_lap[k] = 0; m_lapact[k] = 0; m_ovf[k] = 0;
      end else begin
        os = m_state[k];
        oc = m_cnt[k];
        if (k == 0) m_ovf[k] = 0;
        if (pl) m_cnt[k] = pl_cs;
        else if (os == ST_RUN && ev) begin
          if (oc == FULL_CS - 1) begin
            m_ovf[k] = 1;
            if (k == 0) m_cnt[k] = 0;
            else sat = 1'b1;
          end else begin
            m_cnt[k] = oc + 1;
          end
        end
        if (ss) begin
          if (os == ST_IDLE || os == ST_PAUSE) m_state[k] = ST_RUN;
          else if (os == ST_RUN) m_state[k] = ST_PAUSE;
        end else if (lapp) begin
          if (m_lapact[k]) m_lapact[k] = 0;
          else if (os == ST_RUN) begin m_lap[k] = oc; m_lapact[k] = 1; end
        end
        if (sat) m_state[k] = ST_FULL;
      end
    end
    m_tickd = rst_n ? tick : 1'b1;
  endtask

  task automatic cycle();
    if (tick_on) begin
      tick = (ph >= H);
      ph = (ph + 1) % (2 * H);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [26:0] ex;
      ex = {to_bcd(e_disp[k]), e_run[k], e_lap[k], e_ovf[k]};
      n_vec++;
      if (dv[k] !== ex) begin
        n_bad++;
        $display("FAIL cycle-model inst%0d t=%0t: got %h, want %h", k, $time, dv[k], ex);
      end
    end
  endtask

  // Direct comparison against hand-derived constants
  task automatic tcheck(string nm, int k, int t, bit r, bit l, bit o);
    logic [26:0] ex;
    ex = {to_bcd(t), r, l, o};
    n_vec++;
    if (dv[k] !== ex) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h, want %h", nm, k, dv[k], ex);
    end
  endtask

  task automatic apply_op(int op, int arg);
    int n, guard;
    case (op)
      OP_RST: begin
        tick_on = 0; rst_n = 0; cycle(); rst_n = 1; cycle(); cycle();
      end
      OP_TICKS: begin
        tick_on = 1; n = 0; guard = 0;
        while (n < arg && guard < arg * 2 * H + 20) begin
          cycle();
          if (last_ev) n++;
          guard++;
        end
        if (n < arg) begin
          n_vec++; n_bad++;
          $display("FAIL tick-budget: got %0d ticks, want %0d", n, arg);
        end
        tick_on = 0; cycle(); cycle();
      end
      default: begin
        tick_on = 0;
        ss = (op == OP_SS); clr = (op == OP_CLR); lapp = (op == OP_LAP); pl = (op == OP_LOAD);
        if (op == OP_LOAD) pl_cs = arg;
        cycle();
        ss = 0; clr = 0; lapp = 0; pl = 0;
        cycle(); cycle();
      end
    endcase
  endtask

  // Leave the bench one cycle before a rising tick edge is sampled
  task automatic run_to_ev();
    int guard;
    tick_on = 1; guard = 0;
    while (!((ph >= H) && !m_tickd) && guard < 4 * H) begin
      cycle();
      guard++;
    end
    if (!((ph >= H) && !m_tickd)) begin
      n_vec++; n_bad++;
      $display("FAIL run_to_ev: got no edge, want edge within %0d cycles", 4 * H);
    end
  endtask

  typedef struct {
    int op; int arg;
    int t1; bit r1; bit l1; bit o1;
    int t0; bit r0; bit l0; bit o0;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_tickd = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = ST_IDLE; m_cnt[k] = 0; m_lap[k] = 0; m_lapact[k] = 0; m_ovf[k] = 0;
    end

    tbl[0]  = '{OP_RST,   0,    0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{OP_SS,    0,    0, 1, 0, 0,  0, 1, 0, 0};
    tbl[2]  = '{OP_TICKS, 250,  to_cs(0,2,50), 1, 0, 0,  to_cs(0,2,50), 1, 0, 0};
    tbl[3]  = '{OP_TICKS, 749,  to_cs(0,9,99), 1, 0, 0,  to_cs(0,9,99), 1, 0, 0};
    tbl[4]  = '{OP_TICKS, 1,    to_cs(0,10,0), 1, 0, 0,  to_cs(0,10,0), 1, 0, 0};
    tbl[5]  = '{OP_TICKS, 4999, to_cs(0,59,99), 1, 0, 0, to_cs(0,59,99), 1, 0, 0};
    tbl[6]  = '{OP_TICKS, 1,    to_cs(1,0,0), 1, 0, 0,   to_cs(1,0,0), 1, 0, 0};
    tbl[7]  = '{OP_LOAD,  FULL_CS-1, FULL_CS-1, 1, 0, 0, FULL_CS-1, 1, 0, 0};
    tbl[8]  = '{OP_TICKS, 1,    0, 1, 0, 0,  FULL_CS-1, 0, 0, 1};
    tbl[9]  = '{OP_SS,    0,    0, 0, 0, 0,  FULL_CS-1, 0, 0, 1};
    tbl[10] = '{OP_CLR,   0,    0, 0, 0, 0,  0, 0, 0, 0};
    tbl[11] = '{OP_SS,    0,    0, 1, 0, 0,  0, 1, 0, 0};
    tbl[12] = '{OP_TICKS, 300,  to_cs(0,3,0), 1, 0, 0,  to_cs(0,3,0), 1, 0, 0};
    tbl[13] = '{OP_LAP,   0,    to_cs(0,3,0), 1, 1, 0,  to_cs(0,3,0), 1, 1, 0};
    tbl[14] = '{OP_TICKS, 100,  to_cs(0,3,0), 1, 1, 0,  to_cs(0,3,0), 1, 1, 0};
    tbl[15] = '{OP_LAP,   0,    to_cs(0,4,0), 1, 0, 0,  to_cs(0,4,0), 1, 0, 0};
    tbl[16] = '{OP_SS,    0,    to_cs(0,4,0), 0, 0, 0,  to_cs(0,4,0), 0, 0, 0};
    tbl[17] = '{OP_TICKS, 10,   to_cs(0,4,0), 0, 0, 0,  to_cs(0,4,0), 0, 0, 0};
    tbl[18] = '{OP_LAP,   0,    to_cs(0,4,0), 0, 0, 0,  to_cs(0,4,0), 0, 0, 0};
    tbl[19] = '{OP_CLR,   0,    0, 0, 0, 0,  0, 0, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      apply_op(tbl[i].op, tbl[i].arg);
      tcheck($sformatf("table[%0d]", i), 0, tbl[i].t1, tbl[i].r1, tbl[i].l1, tbl[i].o1);
      tcheck($sformatf("table[%0d]", i), 1, tbl[i].t0, tbl[i].r0, tbl[i].l0, tbl[i].o0);
    end

    // Rollover timing: digits and overflow move one edge after the tick edge
    apply_op(OP_SS, 0);
    apply_op(OP_LOAD, FULL_CS - 1);
    run_to_ev();
    cycle();
    tick_on = 0;
    tcheck("wrap-edgeE", 0, FULL_CS - 1, 1, 0, 0);
    cycle();
    tcheck("wrap-E+1", 0, 0, 1, 0, 1);
    tcheck("sat-E+1", 1, FULL_CS - 1, 0, 0, 1);
    cycle();
    tcheck("wrap-E+2", 0, 0, 1, 0, 0);
    tcheck("sat-E+2", 1, FULL_CS - 1, 0, 0, 1);
    apply_op(OP_CLR, 0);

    // start_stop coinciding with a tick still counts that tick, then pauses
    apply_op(OP_SS, 0);
    apply_op(OP_TICKS, 5);
    run_to_ev();
    ss = 1; cycle(); ss = 0;
    tick_on = 0; cycle(); cycle();
    tcheck("pause-tick", 0, 6, 0, 0, 0);
    apply_op(OP_TICKS, 10);
    tcheck("paused-hold", 0, 6, 0, 0, 0);
    apply_op(OP_CLR, 0);

    // clear + start_stop + tick together: clear wins, tick discarded
    apply_op(OP_SS, 0);
    apply_op(OP_TICKS, 712);
    tcheck("at-07.12", 1, to_cs(0,7,12), 1, 0, 0);
    run_to_ev();
    clr = 1; ss = 1; cycle(); clr = 0; ss = 0;
    tick_on = 0; cycle(); cycle();
    tcheck("clr-ss-tick", 0, 0, 0, 0, 0);
    apply_op(OP_TICKS, 3);
    tcheck("idle-hold", 1, 0, 0, 0, 0);

    // Reset mid-run clears outputs on the reset edge itself
    apply_op(OP_SS, 0);
    apply_op(OP_TICKS, 20);
    apply_op(OP_LAP, 0);
    rst_n = 0; cycle();
    tcheck("rst-midrun", 0, 0, 0, 0, 0);
    tcheck("rst-midrun", 1, 0, 0, 0, 0);
    rst_n = 1; cycle();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick_on = ($urandom_range(0, 15) != 0);
      clr  = ($urandom_range(0, 99) < 2);
      ss   = ($urandom_range(0, 15) == 0);
      lapp = ($urandom_range(0, 15) == 0);
      pl   = ($urandom_range(0, 127) == 0);
      if (pl) pl_cs = ($urandom_range(0, 1) != 0) ? int'($urandom_range(359990, 359999))
                                                  : int'($urandom_range(0, 359999));
      rst_n = ($urandom_range(0, 511) != 0);
      cycle();
    end
    clr = 0; ss = 0; lapp = 0; pl = 0; rst_n = 1;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
